// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - dual-channel button debouncer with registered level and press/release pulses
// Optional macro HOLD_REPEAT_EN adds auto-repeat press pulses while a button is held.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_n,
  output logic [1:0] level,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef HOLD_REPEAT_EN
  localparam int unsigned R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (R_MAX > 1) ? $clog2(R_MAX) : 1;
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [1:0] sync_meta;
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 2'b11;
      sync      <= 2'b11;
    end else begin
      sync_meta <= btn_n;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          level_q, level_nx;
    logic          press_q, press_nx;
    logic          release_q, release_nx;
`ifdef HOLD_REPEAT_EN
    logic [RW-1:0] rcnt, rcnt_nx;
    logic          rphase, rphase_nx;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef HOLD_REPEAT_EN
        rcnt      <= '0;
        rphase    <= 1'b0;
`endif
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
`ifdef HOLD_REPEAT_EN
        rcnt      <= rcnt_nx;
        rphase    <= rphase_nx;
`endif
      end
    end

    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = level_q;
      press_nx   = 1'b0;
      release_nx = 1'b0;
`ifdef HOLD_REPEAT_EN
      rcnt_nx    = rcnt;
      rphase_nx  = rphase;
`endif
      case (state)
        IDLE: begin
          if (!sync[i]) begin
            state_nx = PRESS_WAIT;
            cnt_nx   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync[i]) begin
            state_nx = IDLE;
          end else if (cnt == D_LAST) begin
            state_nx = PRESSED;
            level_nx = 1'b1;
            press_nx = 1'b1;
`ifdef HOLD_REPEAT_EN
            rcnt_nx   = '0;
            rphase_nx = 1'b0;
`endif
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (sync[i]) begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = '0;
          end
`ifdef HOLD_REPEAT_EN
          // rphase selects the initial delay versus the steady repeat period
          else if ((!rphase && rcnt == R_DLY) || (rphase && rcnt == R_PER)) begin
            press_nx  = 1'b1;
            rcnt_nx   = '0;
            rphase_nx = 1'b1;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (!sync[i]) begin
            state_nx = PRESSED;
          end else if (cnt == D_LAST) begin
            state_nx   = IDLE;
            level_nx   = 1'b0;
            release_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    assign level[i]         = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb/tb_btn_debounce_pulse.sv - scoreboard bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4
// Repeat expectations are added when HOLD_REPEAT_EN is defined.
module tb_btn_debounce_pulse;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_n;
  logic [1:0] level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   e0;

  task automatic expect_at(input int cyc, input string tag,
                           input logic [1:0] lvl, input logic [1:0] pr, input logic [1:0] rl);
    exp_t x;
    x.cyc = cyc;
    x.tag = tag;
    x.lvl = lvl;
    x.pr  = pr;
    x.rl  = rl;
    sb.push_back(x);
  endtask

  // Edges with a queued expectation check everything; all other edges must be pulse-free.
  task automatic monitor();
    exp_t x;
    if (!mon_en) return;
    if (sb.size() > 0 && sb[0].cyc == edge_n) begin
      x = sb.pop_front();
      vectors++;
      assert ({level, press_pulse, release_pulse} === {x.lvl, x.pr, x.rl}) else begin
        miscompares++;
        $error("FAIL %s @edge %0d: level/press/release=%b/%b/%b expected %b/%b/%b",
               x.tag, edge_n, level, press_pulse, release_pulse, x.lvl, x.pr, x.rl);
      end
    end else begin
      vectors++;
      assert ({press_pulse, release_pulse} === 4'b0000) else begin
        miscompares++;
        $error("FAIL quiet @edge %0d: press/release=%b/%b expected 00/00",
               edge_n, press_pulse, release_pulse);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      edge_n++;
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_n = 2'b11;
    tick(3);
    mon_en = 1'b1;
    expect_at(edge_n, "reset_state", 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    tick(3);

    // clean press on channel 0
    e0 = edge_n;
    expect_at(e0 + 7, "clean_press", 2'b01, 2'b01, 2'b00);
    expect_at(e0 + 8, "press_drop", 2'b01, 2'b00, 2'b00);
    btn_n = 2'b10;
    tick(10);

    // clean release on channel 0
    e0 = edge_n;
    expect_at(e0 + 7, "clean_release", 2'b00, 2'b00, 2'b01);
    btn_n = 2'b11;
    tick(10);

    // bounce: low 3, high 1, then low held
    e0 = edge_n;
    expect_at(e0 + 11, "bounce_press", 2'b01, 2'b01, 2'b00);
    btn_n = 2'b10;
    tick(3);
    btn_n = 2'b11;
    tick(1);
    btn_n = 2'b10;
    tick(8);

    // 2-cycle release glitch while pressed
    e0 = edge_n;
    expect_at(e0 + 8, "glitch_hold", 2'b01, 2'b00, 2'b00);
    btn_n = 2'b11;
    tick(2);
    btn_n = 2'b10;
    tick(7);

    e0 = edge_n;
    expect_at(e0 + 7, "release_after_glitch", 2'b00, 2'b00, 2'b01);
    btn_n = 2'b11;
    tick(10);

    // reset while channel 1 is mid-debounce with cnt=2
    e0 = edge_n;
    btn_n = 2'b01;
    tick(5);
    reset = 1'b1;
    expect_at(e0 + 6, "reset_mid", 2'b00, 2'b00, 2'b00);
    tick(1);
    reset = 1'b0;
    expect_at(e0 + 13, "press_after_reset", 2'b10, 2'b10, 2'b00);
    tick(10);

    e0 = edge_n;
    expect_at(e0 + 7, "ch1_release", 2'b00, 2'b00, 2'b10);
    btn_n = 2'b11;
    tick(10);

    // simultaneous press, long hold, simultaneous release
    e0 = edge_n;
    expect_at(e0 + 7, "dual_press", 2'b11, 2'b11, 2'b00);
`ifdef HOLD_REPEAT_EN
    for (int k = 0; k < 5; k++)
      expect_at(e0 + 17 + 3 * k, "repeat", 2'b11, 2'b11, 2'b00);
`endif
    btn_n = 2'b00;
    tick(27);
    expect_at(e0 + 34, "dual_release", 2'b00, 2'b00, 2'b11);
    btn_n = 2'b11;
    tick(10);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: %0d expectations pending, expected 0", sb.size());
    end
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
Dual-channel push-button conditioner. It sits directly upstream of the 74xx flip-flop/counter emulations on the STEPFPGA board and turns the two raw, bouncing, active-low board buttons into clean levels and single-cycle edge pulses. Typical use: one channel drives the CLOCK pin of one D flip-flop, the other drives its SET or RESET. Channels are identical and fully independent.

Parameters:
DEBOUNCE_CYCLES, 240000, stable-sample cycles required before a level change is accepted (20 ms at 12 MHz); legal range 2 to 2^24-1.
REPEAT_DELAY, 6000000, cycles held in PRESSED before the first auto-repeat pulse (HOLD_REPEAT_EN only).
REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat pulses (HOLD_REPEAT_EN only); minimum 2.

Ports:
clk  input  1  system clock, 12 MHz board oscillator
reset  input  1  synchronous, active-high reset
btn_n  input  2  raw buttons, active-low, asynchronous to clk; bit i = channel i
level  output  2  debounced state, 1 = pressed
press_pulse  output  2  one-cycle high on an accepted press (and on auto-repeat)
release_pulse  output  2  one-cycle high on an accepted release

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). It is sampled only on the rising edge of clk.
- Synchronizer: 2 flip-flops per channel on btn_n. Reset value is 1 (released). The FSM uses only the second stage (sync).
- Per-channel FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Counter cnt is ceil(log2(DEBOUNCE_CYCLES)) bits wide.
- IDLE: if sync==0, go to PRESS_WAIT and set cnt=0.
- PRESS_WAIT:
  - If sync==1 (bounce), return to IDLE with no pulse.
  - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED: level<=1 and press_pulse<=1 for exactly one cycle.
  - Else cnt<=cnt+1.
- PRESSED: if sync==1, go to RELEASE_WAIT and set cnt=0.
- RELEASE_WAIT: mirror of PRESS_WAIT.
  - If sync==0, return to PRESSED with no pulse.
  - On cnt==DEBOUNCE_CYCLES-1 with sync==1, go to IDLE: level<=0 and release_pulse<=1 for one cycle.
- Latency: btn_n is first sampled low at edge 0 and held. At edge D+2 (D=DEBOUNCE_CYCLES), press_pulse and level go high. press_pulse drops at edge D+3. Release latency is identical.
- All outputs are registered. No combinational path from btn_n to any output.
- press_pulse and release_pulse are never high together on one channel. A new pulse needs at least D+1 cycles since the previous level change.
- Reset values: level=0, press_pulse=0, release_pulse=0, state=IDLE, cnt=0, synchronizer=1.
- Reset mid-debounce or while PRESSED: everything returns to reset values and no pulse is emitted. If the button is still held after reset deasserts, a fresh press is accepted after the full latency.
- Counter never wraps: it saturates logically because a transition always happens at D-1.
- Channels share no state. Simultaneous events on both channels produce simultaneous independent pulses.

Optional Feature:
HOLD_REPEAT_EN
- Defined: each channel adds a repeat counter, active only in PRESSED (not in RELEASE_WAIT) and cleared on entering PRESSED.
  - After REPEAT_DELAY cycles in PRESSED, press_pulse fires for one cycle.
  - press_pulse then fires again every REPEAT_PERIOD cycles while the channel stays PRESSED.
  - Leaving PRESSED (to RELEASE_WAIT) freezes the counter. Returning from a RELEASE_WAIT bounce resumes it without clearing.
  - level is unaffected by repeat.
- Undefined: no repeat logic is synthesized. REPEAT_DELAY and REPEAT_PERIOD are ignored, and press_pulse fires once per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: btn_n[0] driven 1->0 before edge 0 and held -> level[0]=1 and press_pulse[0]=1 after edge 6; press_pulse[0]=0 after edge 7; channel 1 outputs stay 0.
- Bounce rejection: btn_n[0] low 3 cycles, high 1, low again and held -> no pulse from the first burst; a single press_pulse arrives 6 edges after the final low sample.
- Release: from PRESSED, btn_n[0]=1 held -> release_pulse[0]=1 and level[0]=0 after 6 edges; a 2-cycle high glitch while pressed -> no release_pulse, level stays 1.
- Reset mid-operation: reset=1 for 1 cycle while channel 1 is in PRESS_WAIT with cnt=2 -> all outputs 0 on the next edge. With btn_n[1] still low, press_pulse[1] arrives 6 edges after reset deasserts.
- Dual simultaneous: both buttons pressed on the same edge -> press_pulse=2'b11 on the same cycle, and release_pulse=2'b11 on a simultaneous release.
- HOLD_REPEAT_EN defined, button held -> press_pulse at PRESSED entry, again 10 cycles later, then every 3 cycles. Without the macro -> exactly one press_pulse per hold.
